seg_to_hex_capture: RTL

SEG_TO_HEX_CAPTURE -- requirements
Module: seg_to_hex_capture

---
 rtl/seg_to_hex_capture_pkg.sv | 39 +++
 rtl/seg_to_hex_capture_decode.sv | 21 ++
 rtl/seg_to_hex_capture.sv | 124 ++++++++++++
 3 files changed

// File: rtl/seg_to_hex_capture_pkg.sv
// Shared constants and types for the seven-segment capture block.
package seg_to_hex_capture_pkg;

  localparam int unsigned SEG_W   = 7;
  localparam int unsigned NIB_W   = 4;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned ERR_W   = 8;
  localparam int unsigned NUM_PAT = 16;

  // Active-low g..a patterns; entry n decodes to nibble n.
  localparam logic [NUM_PAT-1:0][SEG_W-1:0] SEG_PATTERNS = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // D
    7'b0100111,  // C
    7'b0000011,  // B
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  typedef struct packed {
    logic [IDX_W-1:0] digit;
    logic [NIB_W-1:0] hex;
    logic             err;
  } upd_event_t;

endpackage

// File: rtl/seg_to_hex_capture_decode.sv
// Combinational seven-segment pattern to nibble decoder with match flag.
module seg_pattern_decode
  import seg_to_hex_capture_pkg::*;
(
  input  logic [SEG_W-1:0] pattern,
  output logic [NIB_W-1:0] nibble_c,
  output logic             match_c
);

  always_comb begin
    nibble_c = '0;
    match_c  = 1'b0;
    for (int i = 0; i < NUM_PAT; i++) begin
      if (pattern == SEG_PATTERNS[i]) begin
        nibble_c = NIB_W'(i);
        match_c  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_to_hex_capture.sv
// Captures multiplexed seven-segment digits into nibbles with a 1-deep update slot.
// Optional saturating error counter enabled by SEG_CAPTURE_ERR_COUNT_EN.
module seg_to_hex_capture
  import seg_to_hex_capture_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SEG_W-1:0]        seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  output logic [4*NUM_DIGITS-1:0] hex_out,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    upd_valid,
  input  logic                    upd_ready,
  output logic [IDX_W-1:0]        upd_digit,
  output logic [NIB_W-1:0]        upd_hex,
  output logic                    upd_err,
  output logic                    overflow,
  output logic [ERR_W-1:0]        err_cnt
);

  logic [SEG_W-1:0]      samp_seg;
  logic [NUM_DIGITS-1:0] samp_sel;
  logic [CNT_W-1:0]      stable_cnt;
  logic                  in_onehot_c;
  logic                  samp_onehot_c;
  logic                  commit_c;
  logic [IDX_W-1:0]      idx_c;
  logic [NIB_W-1:0]      nibble_c;
  logic                  match_c;
  upd_event_t            slot_q;

  assign in_onehot_c   = (dig_sel != '0) &&
                         ((dig_sel & (dig_sel - NUM_DIGITS'(1))) == '0);
  assign samp_onehot_c = (samp_sel != '0) &&
                         ((samp_sel & (samp_sel - NUM_DIGITS'(1))) == '0);
  // Counter reaches STABLE_CYCLES-1 exactly once per run, then saturates above it.
  assign commit_c      = samp_onehot_c && (stable_cnt == CNT_W'(STABLE_CYCLES - 1));

  always_comb begin
    idx_c = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (samp_sel[i]) idx_c = IDX_W'(i);
    end
  end

  seg_pattern_decode u_decode (
    .pattern  (samp_seg),
    .nibble_c (nibble_c),
    .match_c  (match_c)
  );

  // Sample stage and stability counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      samp_seg   <= '0;
      samp_sel   <= '0;
      stable_cnt <= '0;
    end else begin
      samp_seg <= seg_in;
      samp_sel <= dig_sel;
      if (!in_onehot_c || seg_in != samp_seg || dig_sel != samp_sel) begin
        stable_cnt <= '0;
      end else if (stable_cnt != CNT_W'(STABLE_CYCLES)) begin
        stable_cnt <= stable_cnt + CNT_W'(1);
      end
    end
  end

  // Per-digit decoded storage; undecodable patterns only drop the valid bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      hex_out     <= '0;
      digit_valid <= '0;
    end else if (commit_c) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (samp_sel[i]) begin
          if (match_c) hex_out[4*i +: 4] <= nibble_c;
          digit_valid[i] <= match_c;
        end
      end
    end
  end

  // Update slot: loads when empty or being drained in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q    <= '0;
      upd_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (commit_c && (!upd_valid || upd_ready)) begin
        upd_valid <= 1'b1;
        slot_q    <= '{digit: idx_c, hex: (match_c ? nibble_c : '0), err: !match_c};
      end else if (upd_valid && upd_ready) begin
        upd_valid <= 1'b0;
      end
      if (commit_c && upd_valid && !upd_ready) overflow <= 1'b1;
    end
  end

  assign upd_digit = slot_q.digit;
  assign upd_hex   = slot_q.hex;
  assign upd_err   = slot_q.err;

`ifdef SEG_CAPTURE_ERR_COUNT_EN
  logic [ERR_W-1:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (commit_c && !match_c && err_cnt_q != '1) begin
      err_cnt_q <= err_cnt_q + ERR_W'(1);
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = '0;
`endif

endmodule
